// File: rtl/spi_adc_stream.sv
// spi_adc_stream: SPI reader for ADCS7476-class serial ADCs, single-shot or fixed-rate.
// SCLK and CS are registered outputs driven from a clk-enable divider; no derived clocks.
module spi_adc_stream #(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned LEAD_Z    = 4,
    parameter int unsigned FRAME_W   = 16,
    parameter int unsigned HALF_DIV  = 4,
    parameter int unsigned QUIET_CYC = 5,
    parameter int unsigned PERIOD    = 2500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              continuous,
    input  logic              read,
    input  logic              miso,
    output logic              sclk,
    output logic              cs,
    output logic [DATA_W-1:0] audio,
    output logic              new_data,
    output logic              busy,
    output logic              overrun,
    output logic              lead_err
);

    localparam int unsigned CNT_MAX = (HALF_DIV > QUIET_CYC) ? HALF_DIV : QUIET_CYC;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned PW      = $clog2(PERIOD + 1);
    localparam int unsigned BW      = $clog2(FRAME_W + 1);

    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_DIV - 1);
    localparam logic [CW-1:0] QUIET_LAST = CW'(QUIET_CYC - 1);
    localparam logic [PW-1:0] PER_LAST   = PW'(PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        QUIET
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [BW-1:0]       bit_cnt;
    logic [PW-1:0]       per_cnt;
    logic [FRAME_W-1:0]  shreg;
    logic                cont_trig;
    logic                trigger;
    logic                lead_any;

    always_comb begin
        cont_trig = continuous && (per_cnt == '0);
        trigger   = cont_trig || (read && !continuous);
        lead_any  = 1'b0;
        for (int unsigned i = 0; i < LEAD_Z; i++) begin
            lead_any = lead_any | shreg[FRAME_W-1-i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cs       <= 1'b1;
            sclk     <= 1'b1;
            audio    <= '0;
            new_data <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            lead_err <= 1'b0;
            per_cnt  <= '0;
            shreg    <= '0;
            cnt      <= '0;
            bit_cnt  <= '0;
        end else begin
            new_data <= 1'b0;

            // Period counter free-runs only while continuous is held; dropping it re-arms at count 0.
            if (!continuous) begin
                per_cnt <= '0;
                overrun <= 1'b0;
            end else begin
                per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + 1'b1;
            end

            if (cont_trig && state != IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (trigger) begin
                        state <= SETUP;
                        cs    <= 1'b0;
                        sclk  <= 1'b1;
                        busy  <= 1'b1;
                        cnt   <= HALF_LAST;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state   <= SHIFT;
                        sclk    <= 1'b0;
                        cnt     <= HALF_LAST;
                        bit_cnt <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!sclk) begin
                        sclk  <= 1'b1;
                        shreg <= {shreg[FRAME_W-2:0], miso};
                        cnt   <= HALF_LAST;
                    end else if (bit_cnt == BIT_LAST) begin
                        state    <= QUIET;
                        cs       <= 1'b1;
                        audio    <= shreg[FRAME_W-LEAD_Z-1 -: DATA_W];
                        lead_err <= lead_any;
                        new_data <= 1'b1;
                        cnt      <= QUIET_LAST;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        sclk    <= 1'b0;
                        cnt     <= HALF_LAST;
                    end
                end
                QUIET: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cs    <= 1'b1;
                    sclk  <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
